// File: rtl/servile_arb_pkg.sv
// rtl/servile_arb_pkg.sv - shared FSM encodings and width helper for the servile N-master arbiter
package servile_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/servile_rr_picker.sv
// rtl/servile_rr_picker.sv - combinational one-hot winner select, round-robin from last+1 or fixed lowest index
module servile_rr_picker #(
  parameter int NM = 2,
  parameter int RR = 1,
  parameter int LW = 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [LW-1:0] i_last,
  output logic [NM-1:0] o_gnt,
  output logic [LW-1:0] o_idx
);

  logic [LW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = i_last;
    w_found = 1'b0;
    if (RR != 0) begin
      // Walk the ring starting just after the last served master.
      for (int k = 0; k < NM; k++) begin
        if (w_cand == LW'(NM - 1)) w_cand = '0;
        else                       w_cand = w_cand + 1'b1;
        if (!w_found && i_req[w_cand]) begin
          w_found = 1'b1;
          o_idx   = w_cand;
        end
      end
    end else begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = LW'(i);
      end
      w_found = |i_req;
    end
    if (w_found) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/servile_rr_arbiter.sv
// rtl/servile_rr_arbiter.sv - N-master Wishbone classic arbiter; timeout enabled by SERVILE_ARB_TIMEOUT_EN
module servile_rr_arbiter
  import servile_arb_pkg::*;
#(
  parameter int NM  = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int RR  = 1,
  parameter int TMO = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NM*AW-1:0]   i_wb_cpu_adr,
  input  logic [NM*DW-1:0]   i_wb_cpu_dat,
  input  logic [NM*DW/8-1:0] i_wb_cpu_sel,
  input  logic [NM-1:0]      i_wb_cpu_we,
  input  logic [NM-1:0]      i_wb_cpu_stb,
  output logic [DW-1:0]      o_wb_cpu_rdt,
  output logic [NM-1:0]      o_wb_cpu_ack,
  output logic [NM-1:0]      o_wb_cpu_err,
  output logic [AW-1:0]      o_wb_mem_adr,
  output logic [DW-1:0]      o_wb_mem_dat,
  output logic [DW/8-1:0]    o_wb_mem_sel,
  output logic               o_wb_mem_we,
  output logic               o_wb_mem_stb,
  input  logic [DW-1:0]      i_wb_mem_rdt,
  input  logic               i_wb_mem_ack
);

  localparam int LW = (NM > 1) ? clog2(NM) : 1;
  localparam int SW = DW / 8;

  logic [0:0]    r_state;
  logic [NM-1:0] r_grant;
  logic [LW-1:0] r_gidx;
  logic [LW-1:0] r_last;

  logic [NM-1:0] w_pick;
  logic [LW-1:0] w_pick_idx;
  logic          w_busy;
  logic          w_gstb;
  logic          w_ack;
  logic          w_expire;

  servile_rr_picker #(
    .NM (NM),
    .RR (RR),
    .LW (LW)
  ) u_picker (
    .i_req  (i_wb_cpu_stb),
    .i_last (r_last),
    .o_gnt  (w_pick),
    .o_idx  (w_pick_idx)
  );

  assign w_busy = (r_state == ST_BUSY);
  assign w_gstb = w_busy & i_wb_cpu_stb[r_gidx];
  // A slave ack only counts while the granted master is actually strobing.
  assign w_ack  = w_gstb & i_wb_mem_ack;

`ifdef SERVILE_ARB_TIMEOUT_EN
  localparam int TW = clog2(TMO + 1);
  logic [TW-1:0] r_tmo;

  assign w_expire = w_gstb & ~i_wb_mem_ack & (r_tmo == TW'(TMO - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_busy) r_tmo <= '0;
    else if (!i_wb_mem_ack) r_tmo <= r_tmo + 1'b1;
  end

  assign o_wb_cpu_err = {NM{w_expire}} & r_grant;
`else
  assign w_expire     = 1'b0;
  assign o_wb_cpu_err = '0;
`endif

  assign o_wb_mem_adr = i_wb_cpu_adr[r_gidx*AW +: AW];
  assign o_wb_mem_dat = i_wb_cpu_dat[r_gidx*DW +: DW];
  assign o_wb_mem_sel = i_wb_cpu_sel[r_gidx*SW +: SW];
  assign o_wb_mem_we  = w_busy & i_wb_cpu_we[r_gidx];
  assign o_wb_mem_stb = w_gstb & ~w_expire;
  assign o_wb_cpu_ack = {NM{w_ack}} & r_grant;
  assign o_wb_cpu_rdt = w_expire ? '0 : i_wb_mem_rdt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= LW'(NM - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_wb_cpu_stb) begin
            r_state <= ST_BUSY;
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
          end
        end
        default: begin
          if (w_ack || w_expire) begin
            r_last  <= r_gidx;
            r_state <= ST_IDLE;
          end else if (!w_gstb) begin
            // Abort: the master withdrew, so its turn does not count.
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servile_rr_arbiter.sv
// tb/tb_servile_rr_arbiter.sv - scoreboard bench for servile_rr_arbiter (RR and fixed instances, NM=3)
module tb_servile_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NM*AW-1:0] cpu_adr [2];
  logic [NM*DW-1:0] cpu_dat [2];
  logic [NM*SW-1:0] cpu_sel [2];
  logic [NM-1:0]    cpu_we  [2];
  logic [NM-1:0]    cpu_stb [2];
  logic [NM-1:0]    cpu_ack [2];
  logic [NM-1:0]    cpu_err [2];
  logic [DW-1:0]    cpu_rdt [2];
  logic [AW-1:0]    mem_adr [2];
  logic [DW-1:0]    mem_dat [2];
  logic [SW-1:0]    mem_sel [2];
  logic             mem_we  [2];
  logic             mem_stb [2];
  logic [DW-1:0]    mem_rdt [2];
  logic             mem_ack [2];

  servile_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .RR(1), .TMO(4)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cpu_adr(cpu_adr[0]), .i_wb_cpu_dat(cpu_dat[0]), .i_wb_cpu_sel(cpu_sel[0]),
    .i_wb_cpu_we(cpu_we[0]), .i_wb_cpu_stb(cpu_stb[0]),
    .o_wb_cpu_rdt(cpu_rdt[0]), .o_wb_cpu_ack(cpu_ack[0]), .o_wb_cpu_err(cpu_err[0]),
    .o_wb_mem_adr(mem_adr[0]), .o_wb_mem_dat(mem_dat[0]), .o_wb_mem_sel(mem_sel[0]),
    .o_wb_mem_we(mem_we[0]), .o_wb_mem_stb(mem_stb[0]),
    .i_wb_mem_rdt(mem_rdt[0]), .i_wb_mem_ack(mem_ack[0])
  );

  servile_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .RR(0), .TMO(4)) u_fx (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cpu_adr(cpu_adr[1]), .i_wb_cpu_dat(cpu_dat[1]), .i_wb_cpu_sel(cpu_sel[1]),
    .i_wb_cpu_we(cpu_we[1]), .i_wb_cpu_stb(cpu_stb[1]),
    .o_wb_cpu_rdt(cpu_rdt[1]), .o_wb_cpu_ack(cpu_ack[1]), .o_wb_cpu_err(cpu_err[1]),
    .o_wb_mem_adr(mem_adr[1]), .o_wb_mem_dat(mem_dat[1]), .o_wb_mem_sel(mem_sel[1]),
    .o_wb_mem_we(mem_we[1]), .o_wb_mem_stb(mem_stb[1]),
    .i_wb_mem_rdt(mem_rdt[1]), .i_wb_mem_ack(mem_ack[1])
  );

  typedef struct {
    int          dut;
    int          m;
    logic        err;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdt;
  } exp_t;

  exp_t exp_q[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   pend      [2][NM];
  int   slv_delay [2];
  int   slv_cnt   [2];
  logic force_ack [2];
  logic [NM-1:0] seen_done [2];
  logic seen_stb [2];
  logic seen_ack [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_master(input int d, input int m, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input logic we);
    cpu_adr[d][m*AW +: AW] = adr;
    cpu_dat[d][m*DW +: DW] = dat;
    cpu_sel[d][m*SW +: SW] = sel;
    cpu_we[d][m]           = we;
  endtask

  task automatic push_exp(input int d, input int m, input logic err);
    exp_t e;
    e.dut = d;
    e.m   = m;
    e.err = err;
    e.adr = cpu_adr[d][m*AW +: AW];
    e.dat = cpu_dat[d][m*DW +: DW];
    e.sel = cpu_sel[d][m*SW +: SW];
    e.we  = cpu_we[d][m];
    e.rdt = err ? 32'h0 : (32'hC0DE_0000 | {16'h0, e.adr[15:0]});
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int d, input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (pend[d][0] == 0) && (pend[d][1] == 0) && (pend[d][2] == 0) && (exp_q.size() == 0);
    end
    check(name, 64'(ok), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_outputs", 64'({mem_stb[d], mem_we[d], cpu_ack[d], cpu_err[d]}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Master and slave models: sample at negedge, drive just after posedge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      cpu_stb[d] = '0;
      mem_ack[d] = 1'b0;
      mem_rdt[d] = '0;
      slv_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        seen_done[d] = cpu_ack[d] | cpu_err[d];
        seen_stb[d]  = mem_stb[d];
        seen_ack[d]  = mem_ack[d];
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int m = 0; m < NM; m++) begin
          if (seen_done[d][m] && pend[d][m] > 0) pend[d][m]--;
          cpu_stb[d][m] = (pend[d][m] > 0);
        end
        if (seen_ack[d]) begin
          mem_ack[d] = force_ack[d];
          slv_cnt[d] = 0;
        end else if (seen_stb[d]) begin
          slv_cnt[d]++;
          mem_ack[d] = force_ack[d] | (slv_delay[d] != 0 && slv_cnt[d] >= slv_delay[d]);
        end else begin
          slv_cnt[d] = 0;
          mem_ack[d] = force_ack[d];
        end
        mem_rdt[d] = 32'hC0DE_0000 | {16'h0, mem_adr[d][15:0]};
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ((cpu_ack[d] | cpu_err[d]) != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 64'({cpu_err[d], cpu_ack[d]}), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("resp_dut", 64'(d), 64'(e.dut));
            if (e.err) begin
              check("err_onehot", 64'({cpu_err[d], cpu_ack[d]}), 64'(1) << (e.m + NM));
              check("err_rdt_zero", 64'(cpu_rdt[d]), 64'(0));
              check("err_stb_low", 64'(mem_stb[d]), 64'(0));
            end else begin
              check("ack_onehot", 64'({cpu_err[d], cpu_ack[d]}), 64'(1) << e.m);
              check("ack_adr", 64'(mem_adr[d]), 64'(e.adr));
              check("ack_we", 64'(mem_we[d]), 64'(e.we));
              check("ack_rdt", 64'(cpu_rdt[d]), 64'(e.rdt));
              if (e.we) check("ack_wdata", 64'({mem_sel[d], mem_dat[d]}), 64'({e.sel, e.dat}));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cpu_adr[d] = '0; cpu_dat[d] = '0; cpu_sel[d] = '0; cpu_we[d] = '0;
      slv_delay[d] = 1; force_ack[d] = 1'b0;
      for (int m = 0; m < NM; m++) pend[d][m] = 0;
    end
    do_reset();

    // Single master 1 read, slave acks after two strobe cycles
    set_master(0, 1, 32'h100, 32'h0, 4'h0, 1'b0);
    slv_delay[0] = 2;
    push_exp(0, 1, 1'b0);
    pend[0][1] = 1;
    @(negedge clk);
    check("single_idle_stb", 64'(mem_stb[0]), 64'(0));
    @(negedge clk);
    check("single_grant_stb", 64'({mem_stb[0], cpu_ack[0]}), 64'({1'b1, 3'b000}));
    wait_done(0, 20, "single_done");

    // Round-robin fairness from reset (last = 2)
    do_reset();
    for (int m = 0; m < NM; m++) set_master(0, m, 32'h1000 + 32'(m * 16), 32'h0, 4'h0, 1'b0);
    slv_delay[0] = 1;
    for (int r = 0; r < 2; r++) for (int m = 0; m < NM; m++) push_exp(0, m, 1'b0);
    for (int m = 0; m < NM; m++) pend[0][m] = 2;
    wait_done(0, 60, "rr_done");

    // Fixed priority: master 0 always wins over master 2
    set_master(1, 0, 32'h2000, 32'h0, 4'h0, 1'b0);
    set_master(1, 2, 32'h2020, 32'h0, 4'h0, 1'b0);
    slv_delay[1] = 1;
    for (int i = 0; i < 4; i++) push_exp(1, 0, 1'b0);
    push_exp(1, 2, 1'b0);
    pend[1][0] = 4;
    pend[1][2] = 1;
    wait_done(1, 60, "fixed_done");

    // Write path, we visible only while granted
    set_master(0, 0, 32'h300, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    slv_delay[0] = 1;
    push_exp(0, 0, 1'b0);
    pend[0][0] = 1;
    @(negedge clk);
    check("write_idle_we", 64'(mem_we[0]), 64'(0));
    @(negedge clk);
    check("write_busy_we", 64'({mem_we[0], mem_stb[0]}), 64'(2'b11));
    wait_done(0, 20, "write_done");
    check("write_after_we", 64'(mem_we[0]), 64'(0));
    set_master(0, 0, 32'h300, 32'h0, 4'h0, 1'b0);

    // Abort mid-transfer, then prove last was not updated (expect 2 then 0)
    slv_delay[0] = 0;
    set_master(0, 2, 32'h400, 32'h0, 4'h0, 1'b0);
    pend[0][2] = 1;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_stb", 64'(mem_stb[0]), 64'(1));
    pend[0][2] = 0;
    @(negedge clk);
    check("abort_stb_drop", 64'({mem_stb[0], cpu_ack[0]}), 64'(0));
    @(negedge clk);
    set_master(0, 0, 32'h500, 32'h0, 4'h0, 1'b0);
    set_master(0, 2, 32'h520, 32'h0, 4'h0, 1'b0);
    slv_delay[0] = 1;
    push_exp(0, 2, 1'b0);
    push_exp(0, 0, 1'b0);
    pend[0][0] = 1;
    pend[0][2] = 1;
    wait_done(0, 30, "abort_last_done");

    // Reset while BUSY drops the transfer
    slv_delay[0] = 2;
    set_master(0, 1, 32'h600, 32'h0, 4'h0, 1'b0);
    pend[0][1] = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy_stb", 64'(mem_stb[0]), 64'(1));
    rst = 1'b1;
    pend[0][1] = 0;
    @(negedge clk);
    check("rst_busy_idle", 64'({mem_stb[0], cpu_ack[0]}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done(0, 10, "rst_busy_quiet");

    // Slave ack while IDLE is never forwarded
    force_ack[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_ack_ignored", 64'({mem_ack[0], cpu_ack[0]}), 64'({1'b1, 3'b000}));
    force_ack[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);

`ifdef SERVILE_ARB_TIMEOUT_EN
    // Timeout with TMO=4: err on the 4th BUSY cycle, then next grant proceeds
    slv_delay[0] = 0;
    set_master(0, 1, 32'h700, 32'h0, 4'h0, 1'b0);
    push_exp(0, 1, 1'b1);
    pend[0][1] = 1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cpu_err[0] != '0) break;
      if (mem_stb[0]) cnt++;
    end
    check("tmo_stb_cycles", 64'(cnt), 64'(3));
    wait_done(0, 10, "tmo_done");
    set_master(0, 2, 32'h720, 32'h0, 4'h0, 1'b0);
    slv_delay[0] = 1;
    push_exp(0, 2, 1'b0);
    pend[0][2] = 1;
    wait_done(0, 20, "tmo_next_done");
`else
    // Without timeout support the arbiter waits indefinitely
    slv_delay[0] = 0;
    set_master(0, 1, 32'h700, 32'h0, 4'h0, 1'b0);
    pend[0][1] = 1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_err[0] != '0) cnt++;
    end
    check("no_tmo_err", 64'(cnt), 64'(0));
    check("no_tmo_stb_held", 64'(mem_stb[0]), 64'(1));
    pend[0][1] = 0;
    repeat (3) @(negedge clk);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
